// File: rtl/mux8_scan_ctrl.sv
// mux8_scan_ctrl: scans enabled channels of an external 8:1 mux and streams captured words out with a valid/ready handshake.
module mux8_scan_ctrl #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [7:0]       ch_mask,
   input  logic [width-1:0] mux_data,
   input  logic             out_ready,
   output logic [2:0]       addr,
   output logic             nCS,
   output logic [width-1:0] out_data,
   output logic [2:0]       out_ch,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, SEL, WAIT} state_t;
   state_t state, state_d;
   logic [2:0] addr_d, out_ch_d;
   logic [width-1:0] out_data_d;
   logic out_valid_d, done_d, mode_q, mode_q_d, stop_q, stop_q_d;
   logic [7:0] mask_q, mask_q_d;
   logic [3:0] lo_in, lo_q, nx;
   // {found, index} of the lowest set bit of m at or above s
   function automatic logic [3:0] first_from(input logic [7:0] m, input logic [3:0] s);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 7; i >= 0; i--)
         if (m[i] && 4'(i) >= s) r = {1'b1, 3'(i)};
      return r;
   endfunction
   assign lo_in = first_from(ch_mask, 4'd0);
   assign lo_q  = first_from(mask_q, 4'd0);
   assign nx    = first_from(mask_q, {1'b0, addr} + 4'd1);
   always_comb begin
      state_d     = state;
      addr_d      = addr;
      out_data_d  = out_data;
      out_ch_d    = out_ch;
      out_valid_d = out_valid;
      done_d      = 1'b0;
      mask_q_d    = mask_q;
      mode_q_d    = mode_q;
      stop_q_d    = stop_q;
      case (state)
         IDLE:
            if (start && !stop) begin
               if (lo_in[3]) begin
                  mask_q_d = ch_mask;
                  mode_q_d = mode;
                  addr_d   = lo_in[2:0];
                  stop_q_d = 1'b0;
                  state_d  = SEL;
               end else
                  done_d = 1'b1;
            end
         SEL:
            if (stop)
               state_d = IDLE;
            else begin
               out_data_d  = mux_data;
               out_ch_d    = addr;
               out_valid_d = 1'b1;
               state_d     = WAIT;
            end
         WAIT:
            if (out_valid && out_ready) begin
               out_valid_d = 1'b0;
               stop_q_d    = 1'b0;
               if (stop || stop_q)
                  state_d = IDLE;
               else if (nx[3]) begin
                  addr_d  = nx[2:0];
                  state_d = SEL;
               end else if (mode_q) begin
                  addr_d  = lo_q[2:0];
                  state_d = SEL;
               end else begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end else if (stop)
               stop_q_d = 1'b1;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr      <= 3'd0;
         nCS       <= 1'b1;
         out_data  <= '0;
         out_ch    <= 3'd0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mask_q    <= 8'd0;
         mode_q    <= 1'b0;
         stop_q    <= 1'b0;
      end else begin
         state     <= state_d;
         addr      <= addr_d;
         nCS       <= state_d != SEL;
         out_data  <= out_data_d;
         out_ch    <= out_ch_d;
         out_valid <= out_valid_d;
         busy      <= state_d != IDLE;
         done      <= done_d;
         mask_q    <= mask_q_d;
         mode_q    <= mode_q_d;
         stop_q    <= stop_q_d;
      end
   end
endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// tb_mux8_scan_ctrl: directed self-checking bench; the mux model returns ch*8'h11 while nCS is low and 8'hEE otherwise.
module tb_mux8_scan_ctrl;
   logic clk = 1'b0, rst_n, start, stop, mode, out_ready;
   logic [7:0] ch_mask, mux_data, out_data;
   logic [2:0] addr, out_ch;
   logic nCS, out_valid, busy, done;
   int errors = 0, checks = 0;
   int seq [5] = '{2, 5, 7, 2, 5};
   always #5 clk = ~clk;
   assign mux_data = nCS ? 8'hEE : {1'b0, addr, 1'b0, addr};
   mux8_scan_ctrl #(.width(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
      .ch_mask(ch_mask), .mux_data(mux_data), .out_ready(out_ready),
      .addr(addr), .nCS(nCS), .out_data(out_data), .out_ch(out_ch),
      .out_valid(out_valid), .busy(busy), .done(done)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; out_ready = 1'b0; ch_mask = 8'h00;
      tick(); tick();
      chk("rst_ncs", nCS, 1); chk("rst_addr", addr, 0); chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_data", out_data, 0); chk("rst_ch", out_ch, 0);
      rst_n = 1'b1;
      tick();
      // full single pass over all eight channels
      ch_mask = 8'hFF; mode = 1'b0; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("p1_first_ncs", nCS, 0); chk("p1_first_addr", addr, 0); chk("p1_busy", busy, 1);
      for (int c = 0; c < 8; c++) begin
         tick();
         chk("p1_valid", out_valid, 1); chk("p1_ch", out_ch, c);
         chk("p1_data", out_data, 8'(c * 8'h11)); chk("p1_wait_ncs", nCS, 1);
         tick();
         chk("p1_valid_drop", out_valid, 0);
         if (c < 7) begin
            chk("p1_next_addr", addr, c + 1); chk("p1_sel_ncs", nCS, 0); chk("p1_done_early", done, 0);
         end else begin
            chk("p1_done", done, 1); chk("p1_end_busy", busy, 0); chk("p1_end_ncs", nCS, 1);
         end
      end
      tick();
      chk("p1_done_pulse", done, 0); chk("p1_idle_addr", addr, 7);
      // continuous wrap over channels 2,5,7 then stop during a WAIT
      ch_mask = 8'b1010_0100; mode = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; mode = 1'b0; ch_mask = 8'h01;
      chk("wr_first_addr", addr, 2);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("wr_ch", out_ch, seq[k]); chk("wr_data", out_data, 8'(seq[k] * 8'h11));
         tick();
         chk("wr_next_addr", addr, seq[k + 1]); chk("wr_busy", busy, 1);
      end
      out_ready = 1'b0;
      tick();
      chk("wr_ch5", out_ch, 5); chk("wr_valid5", out_valid, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("wr_stop_hold_valid", out_valid, 1); chk("wr_stop_hold_busy", busy, 1);
      tick();
      chk("wr_stop_hold2", out_valid, 1); chk("wr_stop_hold_ch", out_ch, 5);
      out_ready = 1'b1;
      tick();
      chk("wr_stop_busy", busy, 0); chk("wr_stop_done", done, 0);
      chk("wr_stop_valid", out_valid, 0); chk("wr_stop_ncs", nCS, 1);
      tick();
      chk("wr_stop_idle_done", done, 0); chk("wr_stop_idle_busy", busy, 0);
      // backpressure: out_ready low for five WAIT cycles, inputs changed while busy
      out_ready = 1'b0; ch_mask = 8'b0000_1000; mode = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("bp_addr", addr, 3); chk("bp_sel_ncs", nCS, 0);
      tick();
      ch_mask = 8'hFF; mode = 1'b1; start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", out_valid, 1); chk("bp_data", out_data, 8'h33);
         chk("bp_ch", out_ch, 3); chk("bp_ncs", nCS, 1);
         tick();
      end
      start = 1'b0; out_ready = 1'b1;
      tick();
      chk("bp_done", done, 1); chk("bp_valid_drop", out_valid, 0); chk("bp_busy", busy, 0);
      tick();
      chk("bp_single_word", out_valid, 0); chk("bp_done_pulse", done, 0); chk("bp_idle_ncs", nCS, 1);
      // stop during SEL, start with empty mask, start+stop together
      ch_mask = 8'h10; start = 1'b1;
      tick();
      start = 1'b0;
      chk("ss_sel_ncs", nCS, 0); chk("ss_sel_addr", addr, 4);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("ss_ncs", nCS, 1); chk("ss_busy", busy, 0); chk("ss_valid", out_valid, 0);
      chk("ss_done", done, 0); chk("ss_no_capture", out_ch, 3);
      ch_mask = 8'h00; start = 1'b1;
      tick();
      start = 1'b0;
      chk("em_done", done, 1); chk("em_ncs", nCS, 1); chk("em_busy", busy, 0);
      tick();
      chk("em_done_pulse", done, 0); chk("em_ncs2", nCS, 1);
      ch_mask = 8'hFF; start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("sp_busy", busy, 0); chk("sp_ncs", nCS, 1); chk("sp_done", done, 0);
      // reset held two cycles in the middle of a WAIT
      ch_mask = 8'h40; out_ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("rw_valid", out_valid, 1); chk("rw_data", out_data, 8'h66);
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      chk("rw_ncs", nCS, 1); chk("rw_valid0", out_valid, 0); chk("rw_addr", addr, 0);
      chk("rw_busy", busy, 0); chk("rw_done", done, 0);
      out_ready = 1'b1;
      tick();
      chk("rw_no_done", done, 0); chk("rw_stay_idle", busy, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mux8_scan_ctrl.md
MUX8_SCAN_CTRL -- requirements
Module: mux8_scan_ctrl

Interface
REQ-001 Parameter: width, default 8, data width of each mux channel and of out_data.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a scan; sampled in IDLE only.
REQ-005 stop  input  1  request to end scanning; sampled in SEL and WAIT.
REQ-006 mode  input  1  0 = single pass, 1 = continuous wrap; sampled with start.
REQ-007 ch_mask  input  8  enabled channels, bit n = channel n; sampled with start.
REQ-008 mux_data  input  width  selected data returned by the downstream 8:1 mux (its Mout).
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 addr  output  3  channel select to the mux.
REQ-011 nCS  output  1  active-low mux enable; low only in SEL.
REQ-012 out_data  output  width  captured channel data.
REQ-013 out_ch  output  3  channel number of out_data.
REQ-014 out_valid  output  1  out_data/out_ch valid.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse on completion of a single pass.

Function
REQ-017 FSM states SHALL be exactly IDLE, SEL and WAIT; every output is registered.
REQ-018 IDLE: start=1, stop=0, ch_mask!=0 -> latch mask_q<=ch_mask and mode_q<=mode, addr<=lowest set bit of ch_mask, go to SEL.
REQ-019 IDLE: start=1, stop=0, ch_mask=0 -> done=1 for one cycle, stay in IDLE, nCS stays 1.
REQ-020 IDLE: start and stop high together -> start ignored.
REQ-021 SEL lasts exactly one cycle with nCS=0; at its closing edge out_data<=mux_data, out_ch<=addr, out_valid<=1, go to WAIT.
REQ-022 WAIT: nCS=1; out_valid, out_data and out_ch held stable until out_valid&&out_ready.
REQ-023 On the handshake, out_valid<=0 on the next edge; next channel = lowest set bit of mask_q strictly above addr.
REQ-024 Next channel exists -> addr<=it, go to SEL.
REQ-025 No next channel, mode_q=1 -> addr<=lowest set bit of mask_q, go to SEL (wrap 7->lower is legal).
REQ-026 No next channel, mode_q=0 -> done=1 for one cycle, go to IDLE.
REQ-027 Throughput with out_ready=1: one word per 2 cycles; first nCS low 1 cycle after start.
REQ-028 stop in SEL -> no capture, nCS<=1, go to IDLE, no done.
REQ-029 stop in WAIT -> pending word still held until handshake, then IDLE, no done; stop is latched until then.
REQ-030 ch_mask/mode changes while busy SHALL have no effect; start while busy ignored.
REQ-031 In IDLE addr holds its last value; nCS=1.

Reset
REQ-032 rst_n=0 at a rising edge from any state -> IDLE, addr=0, nCS=1, out_data=0, out_ch=0, out_valid=0, busy=0, done=0, mask_q=0, mode_q=0, stop latch cleared.
REQ-033 Reset mid-handshake drops out_valid without completion; no done.

Verification
REQ-034 rst_n low 2 cycles mid-WAIT -> next cycle nCS=1, out_valid=0, addr=0, busy=0.
REQ-035 mask 8'hFF, mode=0, out_ready=1, mux model data=ch*8'h11 -> words (0,00),(1,11)...(7,77), one per 2 cycles, done pulse after 7's handshake, busy low next.
REQ-036 mask 8'b1010_0100, mode=1 -> out_ch sequence 2,5,7,2,5,7...; assert stop in a WAIT for ch 5 -> 5 delivered, then IDLE, no done.
REQ-037 out_ready low 5 cycles in WAIT -> out_valid=1, out_data/out_ch unchanged, nCS=1 throughout; single word on release.
REQ-038 stop in SEL -> no out_valid, nCS returns 1, busy low next cycle; start with ch_mask=0 -> done pulse, nCS never low.
